// File: rtl/miriscv_dmem_pkg.sv
// Shared types and widths for the miriscv data-memory responder.
// Optional out-of-range error reporting is enabled by MIRISCV_DMEM_ERR_EN.
package miriscv_dmem_pkg;

  localparam int BE_W   = 4;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/miriscv_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a synchronous read.
// No reset on contents or read register. Used by miriscv_dmem (MIRISCV_DMEM_ERR_EN aware top).
module miriscv_dmem_ram
  import miriscv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           en,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [BE_W-1:0]   lane_we;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign lane_we[gi] = en & we & be[gi];
  end

  // Read register only moves on reads, so it keeps the last read word across writes.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BE_W; i++) begin
      if (lane_we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/miriscv_dmem.sv
// Data-bus memory responder: accepts one access, optionally waits, then pulses rvalid.
// Define MIRISCV_DMEM_ERR_EN to add data_err_o and block out-of-range accesses.
module miriscv_dmem
  import miriscv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [WORD_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [WORD_W-1:0] data_rdata_o
`ifdef MIRISCV_DMEM_ERR_EN
  ,
  output logic              data_err_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [BE_W-1:0]   be_reg;
  logic [AW-1:0]     idx_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              oor_reg;
  logic              rvalid_reg;
  logic              err_reg;
  logic [WORD_W-1:0] rdata_hold_reg;

  logic              accept;
  logic              from_idle;
  logic              from_wait;
  logic              access;
  logic              oor_in;
  logic              acc_we;
  logic              acc_oor;
  logic [BE_W-1:0]   acc_be;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr_bits;

`ifdef MIRISCV_DMEM_ERR_EN
  assign oor_in = |data_addr_i[31:AW+2];
`else
  assign oor_in = 1'b0;
`endif
  assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};

  assign accept    = data_req_i && (state_reg == ST_IDLE);
  assign from_idle = accept && (WAIT_STATES == 0);
  assign from_wait = (state_reg == ST_WAIT) && (cnt_reg == '0);
  assign access    = from_idle || from_wait;

  // Zero-wait accesses use the live bus; delayed ones use the captured copy.
  assign acc_we    = from_idle ? data_we_i            : we_reg;
  assign acc_be    = from_idle ? data_be_i            : be_reg;
  assign acc_idx   = from_idle ? data_addr_i[AW+1:2]  : idx_reg;
  assign acc_wdata = from_idle ? data_wdata_i         : wdata_reg;
  assign acc_oor   = from_idle ? oor_in               : oor_reg;

  miriscv_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i (clk_i),
    .en    (access && !acc_oor),
    .we    (acc_we),
    .be    (acc_be),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      oor_reg        <= 1'b0;
      rvalid_reg     <= 1'b0;
      err_reg        <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      rvalid_reg <= access;
      err_reg    <= access && acc_oor;
      if (accept) begin
        we_reg    <= data_we_i;
        be_reg    <= data_be_i;
        idx_reg   <= data_addr_i[AW+1:2];
        wdata_reg <= data_wdata_i;
        oor_reg   <= oor_in;
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) state_reg <= ST_RESP;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
          if (!we_reg) rdata_hold_reg <= rd_word;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rd_word       = oor_reg ? '0 : ram_rdata;
  assign data_gnt_o    = (state_reg == ST_IDLE);
  assign data_rvalid_o = rvalid_reg;
  assign data_rdata_o  = (state_reg == ST_RESP && !we_reg) ? rd_word : rdata_hold_reg;
`ifdef MIRISCV_DMEM_ERR_EN
  assign data_err_o    = err_reg;
`endif

endmodule

// File: tb/tb_miriscv_dmem.sv
// Directed bench for miriscv_dmem: one zero-wait and one 3-wait-state instance.
// Expectations adapt to MIRISCV_DMEM_ERR_EN when it is defined.
module tb_miriscv_dmem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  miriscv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .resetn_i(resetn), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0])
`ifdef MIRISCV_DMEM_ERR_EN
    , .data_err_o(err[0])
`endif
  );

  miriscv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .resetn_i(resetn), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1])
`ifdef MIRISCV_DMEM_ERR_EN
    , .data_err_o(err[1])
`endif
  );

`ifndef MIRISCV_DMEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int d);
    int waited = 0;
    while (gnt[d] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("gnt_ready", 32'(gnt[d]), 32'd1);
  endtask

  // One access on instance d; returns data/err sampled in the rvalid cycle.
  task automatic do_access(input int d, input logic we_v, input logic [3:0] be_v,
                           input logic [31:0] addr_v, input logic [31:0] wdata_v,
                           input bit scramble, output logic [31:0] rd,
                           output int lat, output logic err_v);
    wait_gnt(d);
    req[d] = 1'b1; we[d] = we_v; be[d] = be_v; addr[d] = addr_v; wdata[d] = wdata_v;
    @(negedge clk);
    req[d] = 1'b0;
    if (scramble) begin
      we[d] = 1'b1; be[d] = 4'hF; addr[d] = 32'h10; wdata[d] = 32'hFFFF_FFFF;
    end
    lat = 1;
    while (rvalid[d] !== 1'b1 && lat < 20) begin
      chk("gnt_low_wait", 32'(gnt[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("gnt_low_resp", 32'(gnt[d]), 32'd0);
    rd    = rdata[d];
    err_v = err[d];
    $display("acc dut%0d we=%0b be=%h addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             d, we_v, be_v, addr_v, wdata_v, rd, err_v, lat);
    if (scramble) begin
      we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        e;
    logic [5:0]  gnt_pat;
    logic [5:0]  rv_pat;
    int          accepts;

    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", 32'(gnt[d]), 32'd1);
      chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_err", 32'(err[d]), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);

    // Full-word write then read, zero wait states.
    do_access(0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, lat, e);
    chk("wr_lat0", 32'(lat), 32'd1);
    chk("wr_rdata_held", rd, 32'h0);
    do_access(0, 1'b0, 4'b0000, 32'h10, 32'h0, 1'b0, rd, lat, e);
    chk("rd_lat0", 32'(lat), 32'd1);
    chk("rd_word", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid[0]), 32'd0);
    chk("rdata_hold_idle", rdata[0], 32'hDEAD_BEEF);

    // Single byte lane write, then be=0 write that must change nothing.
    do_access(0, 1'b1, 4'b0100, 32'h12, 32'h5555_5555, 1'b0, rd, lat, e);
    chk("bytewr_rdata_held", rd, 32'hDEAD_BEEF);
    do_access(0, 1'b0, 4'b0000, 32'h10, 32'h0, 1'b0, rd, lat, e);
    chk("byte_lane", rd, 32'hDE55_BEEF);
    do_access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, rd, lat, e);
    chk("be0_lat", 32'(lat), 32'd1);
    do_access(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, rd, lat, e);
    chk("be0_nowrite", rd, 32'hDE55_BEEF);

    // Three wait states; bus is scrambled while the access is in flight.
    do_access(1, 1'b1, 4'b1111, 32'h40, 32'hCAFE_F00D, 1'b0, rd, lat, e);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    do_access(1, 1'b0, 4'b1111, 32'h40, 32'h0, 1'b1, rd, lat, e);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_captured", rd, 32'hCAFE_F00D);

    // Back-to-back requests held for 6 cycles.
    wait_gnt(0);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
    gnt_pat = '0; rv_pat = '0; accepts = 0;
    for (int i = 0; i < 6; i++) begin
      gnt_pat = {gnt_pat[4:0], gnt[0]};
      if (gnt[0] && req[0]) accepts++;
      @(negedge clk);
      rv_pat = {rv_pat[4:0], rvalid[0]};
    end
    req[0] = 1'b0;
    $display("b2b gnt=%b rvalid=%b accepts=%0d rdata=%h", gnt_pat, rv_pat, accepts, rdata[0]);
    chk("b2b_gnt_pattern", 32'(gnt_pat), 32'b101010);
    chk("b2b_rvalid_pattern", 32'(rv_pat), 32'b101010);
    chk("b2b_accepts", 32'(accepts), 32'd3);
    chk("b2b_rdata", rdata[0], 32'hDE55_BEEF);

    // Reset during WAIT aborts the pending write.
    do_access(1, 1'b1, 4'b1111, 32'h20, 32'h0BAD_F00D, 1'b0, rd, lat, e);
    wait_gnt(1);
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req[1] = 1'b0;
    chk("pre_rst_in_wait", 32'(gnt[1]), 32'd0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt[1]), 32'd1);
    chk("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    chk("midrst_rdata", rdata[1], 32'h0);
    chk("midrst_rdata_dut0", rdata[0], 32'h0);
    $display("reset asserted mid-wait: gnt=%0b rvalid=%0b rdata=%h", gnt[1], rvalid[1], rdata[1]);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_access(1, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, rd, lat, e);
    chk("midrst_old_contents", rd, 32'h0BAD_F00D);

    // Address beyond the RAM: wrap or error depending on build.
    do_access(0, 1'b1, 4'b1111, 32'h0, 32'h1122_3344, 1'b0, rd, lat, e);
    chk("w0_err", 32'(e), 32'd0);
    do_access(0, 1'b1, 4'b1111, 32'h1000, 32'hA5A5_A5A5, 1'b0, rd, lat, e);
`ifdef MIRISCV_DMEM_ERR_EN
    chk("oor_wr_err", 32'(e), 32'd1);
    do_access(0, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b0, rd, lat, e);
    chk("oor_rd_err", 32'(e), 32'd1);
    chk("oor_rd_zero", rd, 32'h0);
    do_access(0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0, rd, lat, e);
    chk("oor_word0_kept", rd, 32'h1122_3344);
    chk("inrange_err", 32'(e), 32'd0);
`else
    chk("wrap_wr_err", 32'(e), 32'd0);
    do_access(0, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b0, rd, lat, e);
    chk("wrap_rd", rd, 32'hA5A5_A5A5);
    do_access(0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0, rd, lat, e);
    chk("wrap_word0", rd, 32'hA5A5_A5A5);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
